// File: rtl/mem_access_unit.sv
// Memory-stage data-bus sequencer: issues one load/store at a time on a
// request/grant/response bus, with lane steering, load extension, misalign and timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        rw,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        op_ready,
  output logic        done,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic       MEM_READ  = 1'b0;
  localparam logic [1:0] STORE_B   = 2'b00;
  localparam logic [1:0] STORE_H   = 2'b01;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        misaligned;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_ext;
  logic        expire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign op_ready = (state == StIdle);
  assign bus_req  = (state == StReq);
  assign expire   = (TIMEOUT != 0) && (cnt == CntLast);

  always_comb begin
    misaligned = 1'b0;
    wstrb_n    = 4'b0000;
    wdata_n    = 32'h0;
    if (rw == MEM_READ) begin
      unique case (load_funct3)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr[0];
        default:        misaligned = (addr[1:0] != 2'b00);
      endcase
    end else begin
      unique case (store_sel)
        STORE_B: begin
          wstrb_n = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        STORE_H: begin
          misaligned = addr[0];
          wstrb_n    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n    = {2{store_data[15:0]}};
        end
        default: begin
          misaligned = (addr[1:0] != 2'b00);
          wstrb_n    = 4'b1111;
          wdata_n    = store_data;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      done       <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= 32'h0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      bus_wstrb  <= 4'b0000;
    end else begin
      done       <= 1'b0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        StIdle: begin
          if (op_valid) begin
            if (misaligned) begin
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state     <= StReq;
              cnt       <= '0;
              f3_q      <= load_funct3;
              off_q     <= addr[1:0];
              bus_we    <= (rw != MEM_READ);
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= wstrb_n;
              bus_wdata <= wdata_n;
            end
          end
        end
        StReq: begin
          cnt <= cnt + 1'b1;
          if (bus_gnt) begin
            if (bus_we) begin
              state <= StIdle;
              done  <= 1'b1;
            end else if (bus_rvalid) begin
              state      <= StIdle;
              done       <= 1'b1;
              load_valid <= 1'b1;
              load_data  <= ld_ext;
            end else begin
              state <= StWait;
            end
          end else if (expire) begin
            state   <= StIdle;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        StWait: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            state      <= StIdle;
            done       <= 1'b1;
            load_valid <= 1'b1;
            load_data  <= ld_ext;
          end else if (expire) begin
            state   <= StIdle;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a default-timeout instance plus a TIMEOUT=4 instance.
module tb_mem_access_unit;

  localparam logic       RD = 1'b0;
  localparam logic       WR = 1'b1;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0, op_valid_t = 1'b0;
  logic        rw = RD;
  logic [1:0]  store_sel = SW;
  logic [2:0]  load_funct3 = 3'b010;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  logic        op_ready, done, load_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  logic        op_ready_t, done_t, load_valid_t, misalign_t, bus_err_t, bus_req_t, bus_we_t;
  logic [31:0] load_data_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_wstrb_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .rw(rw), .store_sel(store_sel),
    .load_funct3(load_funct3), .addr(addr), .store_data(store_data), .op_ready(op_ready),
    .done(done), .load_valid(load_valid), .load_data(load_data), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.TIMEOUT(4), .CNT_W(3)) dut_t (
    .clock(clock), .reset(reset), .op_valid(op_valid_t), .rw(rw), .store_sel(store_sel),
    .load_funct3(load_funct3), .addr(addr), .store_data(store_data), .op_ready(op_ready_t),
    .done(done_t), .load_valid(load_valid_t), .load_data(load_data_t),
    .misalign(misalign_t), .bus_err(bus_err_t), .bus_req(bus_req_t), .bus_we(bus_we_t),
    .bus_addr(bus_addr_t), .bus_wdata(bus_wdata_t), .bus_wstrb(bus_wstrb_t),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load on the main instance: grant at once, rdata one cycle after grant.
  task automatic load_split(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp, input string tag);
    op_valid = 1'b1; rw = RD; load_funct3 = f3; addr = a;
    tick();
    op_valid = 1'b0; bus_gnt = 1'b1;
    check({tag, " req"}, {31'h0, bus_req}, 32'h1);
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
    check({tag, " no early lv"}, {31'h0, load_valid}, 32'h0);
    tick();
    bus_rvalid = 1'b0;
    check({tag, " lv+done"}, {30'h0, load_valid, done}, 32'h3);
    check({tag, " data"}, load_data, exp);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset ready", {31'h0, op_ready}, 32'h1);
    check("reset outs", {26'h0, done, load_valid, misalign, bus_err, bus_req, bus_we}, 32'h0);
    check("reset addr", bus_addr, 32'h0);
    check("reset ldata", load_data, 32'h0);

    // SB with immediate grant
    op_valid = 1'b1; rw = WR; store_sel = SB; addr = 32'h1003; store_data = 32'h0000_00A5;
    tick();
    op_valid = 1'b0; bus_gnt = 1'b1;
    check("sb ready low", {31'h0, op_ready}, 32'h0);
    check("sb req/we", {30'h0, bus_req, bus_we}, 32'h3);
    check("sb addr", bus_addr, 32'h1000);
    check("sb wstrb", {28'h0, bus_wstrb}, 32'h8);
    check("sb wdata", bus_wdata, 32'hA5A5_A5A5);
    tick();
    bus_gnt = 1'b0;
    check("sb done", {31'h0, done}, 32'h1);
    check("sb ready back", {31'h0, op_ready}, 32'h1);
    check("sb req off", {31'h0, bus_req}, 32'h0);
    tick();
    check("sb done pulse", {31'h0, done}, 32'h0);

    load_split(3'b001, 32'h2002, 32'h8001_1234, 32'hFFFF_8001, "lh");
    check("lh wstrb", {28'h0, bus_wstrb}, 32'h0);
    load_split(3'b101, 32'h2002, 32'h8001_1234, 32'h0000_8001, "lhu");
    load_split(3'b000, 32'h2001, 32'h8001_1234, 32'h0000_0012, "lb");
    tick();
    check("lv pulse", {31'h0, load_valid}, 32'h0);
    check("ldata held", load_data, 32'h0000_0012);

    // Misaligned SW and LH
    op_valid = 1'b1; rw = WR; store_sel = SW; addr = 32'h3002;
    tick();
    op_valid = 1'b0;
    check("sw mis", {29'h0, done, misalign, bus_req}, 32'h6);
    check("sw mis ready", {31'h0, op_ready}, 32'h1);
    tick();
    check("sw mis pulse", {29'h0, done, misalign, bus_req}, 32'h0);
    op_valid = 1'b1; rw = RD; load_funct3 = 3'b001; addr = 32'h3001;
    tick();
    op_valid = 1'b0;
    check("lh mis", {29'h0, done, misalign, bus_req}, 32'h6);
    check("lh mis ready", {31'h0, op_ready}, 32'h1);

    // SH with grant withheld 5 cycles
    op_valid = 1'b1; rw = WR; store_sel = SH; addr = 32'h4002; store_data = 32'h0000_BEEF;
    tick();
    op_valid = 1'b0; addr = 32'h0; store_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("sh req", {31'h0, bus_req}, 32'h1);
      check("sh addr", bus_addr, 32'h4000);
      check("sh wstrb", {28'h0, bus_wstrb}, 32'hC);
      check("sh wdata", bus_wdata, 32'hBEEF_BEEF);
      check("sh no done", {31'h0, done}, 32'h0);
      tick();
    end
    bus_gnt = 1'b1;
    check("sh req at gnt", {31'h0, bus_req}, 32'h1);
    tick();
    bus_gnt = 1'b0;
    check("sh done", {30'h0, done, bus_err}, 32'h2);

    // TIMEOUT=4 instance: prime load_data, then time out, then recover
    op_valid_t = 1'b1; rw = RD; load_funct3 = 3'b010; addr = 32'h5000;
    tick();
    op_valid_t = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check("t lw done", {30'h0, load_valid_t, done_t}, 32'h3);
    check("t lw data", load_data_t, 32'hCAFE_F00D);
    op_valid_t = 1'b1; addr = 32'h5004;
    tick();
    op_valid_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t req held", {31'h0, bus_req_t}, 32'h1);
      check("t no done", {31'h0, done_t}, 32'h0);
      tick();
    end
    check("t req drop", {31'h0, bus_req_t}, 32'h0);
    check("t err", {29'h0, done_t, bus_err_t, load_valid_t}, 32'h6);
    check("t data held", load_data_t, 32'hCAFE_F00D);
    check("t ready", {31'h0, op_ready_t}, 32'h1);
    op_valid_t = 1'b1; load_funct3 = 3'b100; addr = 32'h6003;
    tick();
    op_valid_t = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h7F00_0000;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check("t lbu done", {29'h0, done_t, bus_err_t, load_valid_t}, 32'h5);
    check("t lbu data", load_data_t, 32'h0000_007F);

    // Reset while in WAIT, then a late rvalid
    op_valid = 1'b1; rw = RD; load_funct3 = 3'b010; addr = 32'h8000;
    tick();
    op_valid = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check("w in wait", {30'h0, bus_req, op_ready}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst ready", {31'h0, op_ready}, 32'h1);
    check("rst outs", {26'h0, done, load_valid, misalign, bus_err, bus_req, bus_we}, 32'h0);
    check("rst ldata", load_data, 32'h0);
    check("rst bus", bus_addr | bus_wdata | {28'h0, bus_wstrb}, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_rvalid = 1'b0;
    check("late rvalid", {30'h0, done, load_valid}, 32'h0);
    op_valid = 1'b1; rw = WR; store_sel = SW; addr = 32'h7000; store_data = 32'h0BAD_CAFE;
    tick();
    op_valid = 1'b0; bus_gnt = 1'b1;
    check("post rst wdata", bus_wdata, 32'h0BAD_CAFE);
    check("post rst wstrb", {28'h0, bus_wstrb}, 32'hF);
    tick();
    bus_gnt = 1'b0;
    check("post rst done", {31'h0, done}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-bus sequencer that sits directly downstream of the store/load decode stage.
- Consumes the registered `rw`/`store_sel` controls plus address, store data and load funct3, and performs the access on a word-wide request/grant/response data bus.
- Handles byte-lane steering, load extraction and extension, misalignment detection and a bus timeout.
- Stalls the pipeline through `op_ready` while an access is in flight.

Parameters:
- TIMEOUT, 255: max cycles spent in REQ+WAIT before the access is aborted; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  MEM-stage instruction is a load/store
- rw  in  1  `MEM_READ` / `MEM_WRITE` (codes.v encodings)
- store_sel  in  2  `STORE_W` / `STORE_H` / `STORE_B`
- load_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr  in  32  byte address
- store_data  in  32  store operand, data in low bits
- op_ready  out  1  high only in IDLE; op accepted when op_valid&op_ready
- done  out  1  one-cycle pulse when an accepted op retires, including faults
- load_valid  out  1  one-cycle pulse, load_data valid
- load_data  out  32  extended load result, held until next load_valid
- misalign  out  1  one-cycle pulse with done, access not issued
- bus_err  out  1  one-cycle pulse with done on timeout
- bus_req  out  1  request, held until bus_gnt
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables; 0 for reads
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data word

Behaviour:
- Reset values: state IDLE; all outputs 0, except op_ready = 1.
- Reset mid-access: bus_req drops at that edge; no done or load_valid is produced; later bus_rvalid is ignored until the next accepted load.
- States: IDLE, REQ, WAIT. done, load_valid, misalign and bus_err are registered pulses.
- IDLE, on acceptance, latches rw, store_sel, load_funct3, addr[1:0], the bus fields and lane data.
- Misalignment check:
  - Halfword (STORE_H, LH, LHU) with addr[0] = 1 is misaligned.
  - Word (STORE_W, LW) with addr[1:0] != 0 is misaligned.
  - Result: next cycle done = 1 and misalign = 1; no bus_req; state stays IDLE.
- Aligned access: next cycle is REQ with bus_req = 1; the counter clears on entry.
- REQ:
  - Bus outputs are stable until bus_gnt.
  - Write + gnt: to IDLE, done next cycle.
  - Read + gnt: to WAIT, unless bus_rvalid is also high that cycle, in which case the read completes immediately.
- WAIT: bus_req = 0; on bus_rvalid, extract data, set load_valid = done = 1 next cycle, go to IDLE.
- Completion to IDLE: op_ready is high in the same cycle as the done pulse, so back-to-back accesses are allowed.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = store_data.
  - Reads: wstrb = 0, wdata = 0.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 is treated as LW.
- Timeout: counter increments each cycle in REQ/WAIT. When TIMEOUT != 0 and counter == TIMEOUT-1 without completion:
  - bus_req drops and state goes to IDLE.
  - Next cycle: done = 1 and bus_err = 1; load_data is unchanged and load_valid = 0.
  - A completion in the same cycle as expiry wins.
- Latency with zero-wait bus: store done at +2 cycles; load load_valid at +3 cycles when gnt and rvalid are separate, +2 when simultaneous.

Test Plan:
- Reset, then SB addr=0x1003 data=0x000000A5, gnt immediate -> bus_addr=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5, done at +2, op_ready low for exactly 1 cycle.
- LH addr=0x2002, rdata=0x8001_1234 one cycle after gnt -> load_data=0xFFFF8001, load_valid at +3; LHU same -> 0x00008001; LB addr=0x2001 -> 0x00000012.
- SW addr=0x3002 -> misalign = done = 1 next cycle, bus_req never asserted, op_ready stays 1; LH addr=0x3001 -> same.
- gnt withheld 5 cycles on SH addr=0x4002 data=0xBEEF -> bus_req, bus_addr, wstrb=4'b1100 and wdata=0xBEEFBEEF stable all 5 cycles, done one cycle after gnt.
- TIMEOUT=4, load with no gnt -> bus_req high 4 cycles, then bus_err = done = 1, load_valid = 0, load_data holds its old value; a following load completes normally.
- reset asserted while in WAIT, then late bus_rvalid -> no load_valid or done, all outputs at reset values, next op accepted normally.
